// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding, segment
// target codes and the default end-of-stream marker.
package program_loader_pkg;

   typedef enum logic [3:0] {
      IDLE,
      HDR_TGT,
      HDR_ADDR,
      HDR_CNT,
      DATA_HI,
      DATA_LO,
      WRITE,
      RUN,
      HALTED,
      ERROR
   } state_t;

   localparam logic [7:0] TGT_IM   = 8'h00;
   localparam logic [7:0] TGT_DM   = 8'h01;
   localparam logic [7:0] END_MARK = 8'hFF;

   // States in which the loader takes a byte from the stream.
   function automatic logic accepts_byte(input state_t s);
      return (s == HDR_TGT) || (s == HDR_ADDR) || (s == HDR_CNT) ||
             (s == DATA_HI) || (s == DATA_LO);
   endfunction

endpackage

// File: rtl/loader_byte_sink.sv
// Stream acceptance and word assembly for the program loader.
//   clk, clr   : clock, asynchronous active-high reset
//   rdy_nxt    : in_ready value for the next cycle (decoded from next state)
//   start      : session restart; a byte offered in the same cycle is dropped
//   take_hi    : current byte is the high half of a data word
//   in_valid/in_data/in_ready : byte stream handshake
//   xfer       : a byte transfers at the coming clock edge
//   word       : {latched high byte, current stream byte}
module loader_byte_sink (
   input  logic        clk,
   input  logic        clr,
   input  logic        rdy_nxt,
   input  logic        start,
   input  logic        take_hi,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        xfer,
   output logic [15:0] word
);

   logic [7:0] hi_p0;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) in_ready <= 1'b0;
      else     in_ready <= rdy_nxt;
   end

   // High byte is pure data; it is always rewritten before it is used.
   always_ff @(posedge clk) begin
      if (xfer && take_hi) hi_p0 <= in_data;
   end

   assign xfer = in_valid && in_ready && !start;
   assign word = {hi_p0, in_data};

endmodule

// File: rtl/program_loader.sv
// Program loader: parses a segmented byte stream and writes 16-bit words into
// the datapath's instruction or data memory through the external test ports,
// then releases the CPU on the end marker and gates its clock after a halt.
//   clk, clr                 : clock, asynchronous active-high reset
//   start                    : begin (or restart) a load session
//   in_valid/in_data/in_ready: byte stream handshake
//   halt_req                 : HLT decoded by the control unit while running
//   test_normal, cpu_clr     : memory mux select / datapath reset (high while loading)
//   flag_HLT                 : datapath clock enable, low only when halted
//   ext_instr_*, ext_data_*  : registered memory write ports
//   done, error              : CPU released / stream rejected
module program_loader #(
   parameter int         ADDR_W   = 8,
   parameter logic [7:0] END_MARK = program_loader_pkg::END_MARK
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        start,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   input  logic        halt_req,
   output logic        test_normal,
   output logic        cpu_clr,
   output logic        flag_HLT,
   output logic        ext_instr_we,
   output logic [15:0] ext_instr_addr,
   output logic [15:0] ext_instr_data,
   output logic        ext_data_write_en,
   output logic [15:0] ext_data_addr,
   output logic [15:0] ext_data_data,
   output logic        done,
   output logic        error
);

   import program_loader_pkg::state_t, program_loader_pkg::accepts_byte,
          program_loader_pkg::TGT_IM, program_loader_pkg::TGT_DM,
          program_loader_pkg::IDLE, program_loader_pkg::HDR_TGT,
          program_loader_pkg::HDR_ADDR, program_loader_pkg::HDR_CNT,
          program_loader_pkg::DATA_HI, program_loader_pkg::DATA_LO,
          program_loader_pkg::WRITE, program_loader_pkg::RUN,
          program_loader_pkg::HALTED, program_loader_pkg::ERROR;

   // One bit wider than both the address and the count so the end-of-segment
   // sum cannot overflow during the range check.
   localparam int              CW    = ((ADDR_W > 8) ? ADDR_W : 8) + 1;
   localparam logic [CW-1:0]   DEPTH = CW'(2 ** ADDR_W);

   state_t              state, state_nxt;
   logic                dm_sel;
   logic [ADDR_W-1:0]   addr_q;
   logic [7:0]          cnt_q;
   logic                xfer;
   logic [15:0]         word;
   logic [CW-1:0]       span;

   assign span = CW'(addr_q) + CW'(in_data);

   loader_byte_sink u_sink (
      .clk      (clk),
      .clr      (clr),
      .rdy_nxt  (accepts_byte(state_nxt)),
      .start    (start),
      .take_hi  (state == DATA_HI),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .xfer     (xfer),
      .word     (word)
   );

   always_comb begin
      state_nxt = state;
      if (start) begin
         state_nxt = HDR_TGT;
      end else begin
         case (state)
            HDR_TGT:
               if (xfer) begin
                  if (in_data == END_MARK)                          state_nxt = RUN;
                  else if (in_data == TGT_IM || in_data == TGT_DM)  state_nxt = HDR_ADDR;
                  else                                              state_nxt = ERROR;
               end
            HDR_ADDR: if (xfer) state_nxt = HDR_CNT;
            HDR_CNT:
               if (xfer) begin
                  if (in_data == 8'd0)    state_nxt = HDR_TGT;
                  else if (span > DEPTH)  state_nxt = ERROR;
                  else                    state_nxt = DATA_HI;
               end
            DATA_HI: if (xfer) state_nxt = DATA_LO;
            DATA_LO: if (xfer) state_nxt = WRITE;
            WRITE:   state_nxt = (cnt_q == 8'd1) ? HDR_TGT : DATA_HI;
            RUN:     if (halt_req) state_nxt = HALTED;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state             <= IDLE;
         dm_sel            <= 1'b0;
         addr_q            <= '0;
         cnt_q             <= '0;
         test_normal       <= 1'b1;
         cpu_clr           <= 1'b1;
         flag_HLT          <= 1'b1;
         done              <= 1'b0;
         error             <= 1'b0;
         ext_instr_we      <= 1'b0;
         ext_instr_addr    <= '0;
         ext_instr_data    <= '0;
         ext_data_write_en <= 1'b0;
         ext_data_addr     <= '0;
         ext_data_data     <= '0;
      end else begin
         state       <= state_nxt;
         test_normal <= !(state_nxt == RUN || state_nxt == HALTED);
         cpu_clr     <= !(state_nxt == RUN || state_nxt == HALTED);
         done        <=  (state_nxt == RUN || state_nxt == HALTED);
         flag_HLT    <=  (state_nxt != HALTED);
         error       <=  (state_nxt == ERROR);

         // Write port is loaded on entry to WRITE so address, data and enable
         // are stable for the whole WRITE cycle, including the RAM's negedge.
         ext_instr_we      <= (state_nxt == WRITE) && !dm_sel;
         ext_data_write_en <= (state_nxt == WRITE) &&  dm_sel;
         if (state_nxt == WRITE) begin
            if (dm_sel) begin
               ext_data_addr  <= 16'(addr_q);
               ext_data_data  <= word;
            end else begin
               ext_instr_addr <= 16'(addr_q);
               ext_instr_data <= word;
            end
         end

         if (start) begin
            dm_sel <= 1'b0;
            addr_q <= '0;
            cnt_q  <= '0;
         end else begin
            case (state)
               HDR_TGT:  if (xfer) dm_sel <= (in_data == TGT_DM);
               HDR_ADDR: if (xfer) addr_q <= ADDR_W'(in_data);
               HDR_CNT:  if (xfer) cnt_q  <= in_data;
               WRITE: begin
                  addr_q <= addr_q + ADDR_W'(1);
                  cnt_q  <= cnt_q - 8'd1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule
